// File: rtl/nmr_vote_monitor.sv
// N-modular-redundancy voter with per-core error tracking, quarantine and a
// hold/rollback handshake towards the recovery logic.
module nmr_vote_monitor #(
  parameter int N_CORES    = 3,
  parameter int BUNDLE_W   = 97,
  parameter int ERR_THRESH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_in,
  input  logic                          en_i,
  input  logic [N_CORES*BUNDLE_W-1:0]   core_bus_i,
  input  logic                          recovery_ack_i,
  output logic [BUNDLE_W-1:0]           voted_o,
  output logic [N_CORES-1:0]            disagree_o,
  output logic [N_CORES-1:0]            core_fail_o,
  output logic                          hold_o,
  output logic                          rollback_o,
  output logic                          no_majority_o,
  output logic [CNT_W-1:0]              rollback_cnt_o,
  output logic [1:0]                    state_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    HOLD     = 2'd1,
    ROLLBACK = 2'd2,
    FATAL    = 2'd3
  } st_e;

  st_e                              st_q, st_d;
  logic [CNT_W-1:0]                 rb_cnt_q, rb_cnt_d;
  logic                             rb_bump;

  logic [N_CORES-1:0][BUNDLE_W-1:0] bun;
  logic [N_CORES-1:0]               fail_q, fail_d;
  logic [N_CORES-1:0]               active;
  logic [BUNDLE_W-1:0]              tie_bits;
  logic [3:0]                       act_cnt, post_cnt;
  logic                             tie_any;

  function automatic logic [3:0] popc(input logic [N_CORES-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < N_CORES; i++) c = c + 4'(v[i]);
    return c;
  endfunction

  assign bun      = core_bus_i;
  assign active   = ~fail_q;
  assign act_cnt  = popc(active);
  assign post_cnt = popc(~fail_d);
  assign tie_any  = |tie_bits;

  // Column-wise majority over the active cores; 2*ones == A flags a tie.
  for (genvar b = 0; b < BUNDLE_W; b++) begin : g_bit
    logic [N_CORES-1:0] col;
    logic [3:0]         ones;
    always_comb begin
      col = '0;
      for (int k = 0; k < N_CORES; k++) col[k] = bun[k][b];
    end
    assign ones        = popc(col & active);
    assign voted_o[b]  = ({ones, 1'b0} > {1'b0, act_cnt});
    assign tie_bits[b] = ({ones, 1'b0} == {1'b0, act_cnt});
  end

  // Per-core saturating error counter and sticky quarantine bit.
  for (genvar k = 0; k < N_CORES; k++) begin : g_core
    logic [3:0] err_cnt_q, err_cnt_d;

    assign disagree_o[k] = en_i & (st_q == RUN) & active[k] & (bun[k] != voted_o);
    assign err_cnt_d     = (disagree_o[k] && err_cnt_q < 4'(ERR_THRESH)) ?
                           err_cnt_q + 4'd1 : err_cnt_q;
    assign fail_d[k]     = fail_q[k] | (err_cnt_d == 4'(ERR_THRESH));

    always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
        err_cnt_q <= '0;
        fail_q[k] <= 1'b0;
      end else begin
        err_cnt_q <= err_cnt_d;
        fail_q[k] <= fail_d[k];
      end
    end
  end

  assign core_fail_o = fail_q;

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      st_q     <= RUN;
      rb_cnt_q <= '0;
    end else begin
      st_q     <= st_d;
      rb_cnt_q <= rb_cnt_d;
    end
  end

  // A tie outranks a plain disagreement; losing the 2-core quorum is fatal.
  always_comb begin
    st_d    = st_q;
    rb_bump = 1'b0;
    case (st_q)
      RUN: begin
        if (en_i) begin
          if (tie_any || act_cnt < 4'd2) begin
            st_d = FATAL;
          end else if (|disagree_o) begin
            if (post_cnt < 4'd2) begin
              st_d = FATAL;
            end else begin
              st_d    = HOLD;
              rb_bump = 1'b1;
            end
          end
        end
      end
      HOLD:     st_d = ROLLBACK;
      ROLLBACK: if (recovery_ack_i) st_d = RUN;
      default:  st_d = FATAL;
    endcase
  end

  assign rb_cnt_d = (rb_bump && rb_cnt_q != '1) ? rb_cnt_q + 1'b1 : rb_cnt_q;

  always_comb begin
    hold_o         = (st_q != RUN);
    rollback_o     = (st_q == ROLLBACK);
    no_majority_o  = (st_q == FATAL);
    rollback_cnt_o = rb_cnt_q;
    state_o        = st_q;
  end

endmodule

// File: tb/tb_nmr_vote_monitor.sv
// Directed bench: 3-core/threshold-2 instance for the handshake, quarantine,
// tie and reset cases, plus a 5-core instance for a double-corruption vote.
module tb_nmr_vote_monitor;
  localparam int BW = 97;
  localparam logic [BW-1:0] V = 97'h1_2345_6789_abcd_ef01_2345_6789;
  localparam logic [BW-1:0] W = 97'h0_dead_beef_0bad_f00d_cafe_1357;

  logic clk, rst_in;
  int checks, failures;

  logic [3*BW-1:0] bus_a;
  logic            en_a, ack_a;
  logic [BW-1:0]   voted_a;
  logic [2:0]      dis_a, fail_a;
  logic            hold_a, rb_a, nm_a;
  logic [15:0]     rbc_a;
  logic [1:0]      st_a;

  logic [5*BW-1:0] bus_b;
  logic            en_b, ack_b;
  logic [BW-1:0]   voted_b;
  logic [4:0]      dis_b, fail_b;
  logic            hold_b, rb_b, nm_b;
  logic [15:0]     rbc_b;
  logic [1:0]      st_b;

  nmr_vote_monitor #(.N_CORES(3), .BUNDLE_W(BW), .ERR_THRESH(2), .CNT_W(16)) u_a (
    .clk(clk), .rst_in(rst_in), .en_i(en_a), .core_bus_i(bus_a),
    .recovery_ack_i(ack_a), .voted_o(voted_a), .disagree_o(dis_a),
    .core_fail_o(fail_a), .hold_o(hold_a), .rollback_o(rb_a),
    .no_majority_o(nm_a), .rollback_cnt_o(rbc_a), .state_o(st_a));

  nmr_vote_monitor #(.N_CORES(5), .BUNDLE_W(BW), .ERR_THRESH(4), .CNT_W(16)) u_b (
    .clk(clk), .rst_in(rst_in), .en_i(en_b), .core_bus_i(bus_b),
    .recovery_ack_i(ack_b), .voted_o(voted_b), .disagree_o(dis_b),
    .core_fail_o(fail_b), .hold_o(hold_b), .rollback_o(rb_b),
    .no_majority_o(nm_b), .rollback_cnt_o(rbc_b), .state_o(st_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3*BW-1:0] mk3(input logic [BW-1:0] c0, c1, c2);
    return {c2, c1, c0};
  endfunction

  initial begin
    checks = 0; failures = 0;
    clk = 0; rst_in = 1;
    en_a = 0; ack_a = 0; bus_a = mk3(V, V, V);
    en_b = 0; ack_b = 0; bus_b = {W, W, W, W, W};
    #1 rst_in = 0;
    #1;
    chk("rst_state", st_a, 0);
    chk("rst_hold", hold_a, 0);
    chk("rst_rb", rb_a, 0);
    chk("rst_nomaj", nm_a, 0);
    chk("rst_fail", fail_a, 0);
    chk("rst_rbcnt", rbc_a, 0);
    tick();
    rst_in = 1;
    tick();

    // clean run
    en_a = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("clean_vote", voted_a, V);
      chk("clean_dis", dis_a, 0);
      tick();
    end
    chk("clean_hold", hold_a, 0);
    chk("clean_rbcnt", rbc_a, 0);

    // single-bit upset on core 1
    bus_a = mk3(V, V ^ 97'h1, V);
    #1;
    chk("upset_dis", dis_a, 3'b010);
    chk("upset_vote", voted_a, V);
    tick();
    chk("upset_st_hold", st_a, 1);
    chk("upset_hold", hold_a, 1);
    chk("upset_rb_low", rb_a, 0);
    chk("hold_dis_masked", dis_a, 0);
    tick();
    bus_a = mk3(V, V, V);
    chk("upset_st_rb", st_a, 2);
    chk("upset_rb", rb_a, 1);
    repeat (3) tick();
    chk("rb_wait", st_a, 2);
    ack_a = 1;
    tick();
    ack_a = 0;
    chk("ack_st_run", st_a, 0);
    chk("ack_hold", hold_a, 0);
    chk("ack_rb", rb_a, 0);
    chk("ack_rbcnt", rbc_a, 1);
    chk("ack_fail", fail_a, 0);

    // second upset on core 1 reaches the threshold
    bus_a = mk3(V, V ^ 97'h20, V);
    tick();
    chk("q_fail", fail_a, 3'b010);
    chk("q_st_hold", st_a, 1);
    chk("q_rbcnt", rbc_a, 2);
    bus_a = mk3(V, ~V, V);
    tick();
    ack_a = 1;
    tick();
    ack_a = 0;
    chk("q_st_run", st_a, 0);
    #1;
    chk("q_vote", voted_a, V);
    chk("q_dis", dis_a, 0);
    repeat (3) tick();
    chk("q_hold", hold_a, 0);
    chk("q_st", st_a, 0);

    // cores 0 and 2 split with only two active: tie
    bus_a = mk3(V, ~V, V ^ 97'h8);
    #1;
    chk("tie_vote", voted_a, V & ~97'h8);
    tick();
    chk("tie_st", st_a, 3);
    chk("tie_nomaj", nm_a, 1);
    chk("tie_hold", hold_a, 1);
    chk("tie_rb", rb_a, 0);
    ack_a = 1;
    repeat (3) tick();
    ack_a = 0;
    chk("fatal_sticky", st_a, 3);
    chk("fatal_nomaj", nm_a, 1);
    chk("fatal_vote", voted_a, V & ~97'h8);

    // reset out of FATAL, then async reset mid-ROLLBACK
    rst_in = 0;
    #1;
    chk("r1_st", st_a, 0);
    chk("r1_nomaj", nm_a, 0);
    chk("r1_fail", fail_a, 0);
    tick();
    rst_in = 1;
    bus_a = mk3(V, V, V);
    tick();
    bus_a = mk3(V, V ^ 97'h2, V);
    tick();
    chk("r2_st_hold", st_a, 1);
    bus_a = mk3(V, V, V);
    tick();
    chk("r2_st_rb", st_a, 2);
    #3 rst_in = 0;
    #1;
    chk("r2_st", st_a, 0);
    chk("r2_rb", rb_a, 0);
    chk("r2_hold", hold_a, 0);
    chk("r2_rbcnt", rbc_a, 0);
    chk("r2_fail", fail_a, 0);
    #1 rst_in = 1;
    tick();
    // err count cleared: one more upset must not quarantine at threshold 2
    bus_a = mk3(V, V ^ 97'h4, V);
    tick();
    chk("r3_fail", fail_a, 0);
    chk("r3_st", st_a, 1);
    chk("r3_rbcnt", rbc_a, 1);
    bus_a = mk3(V, V, V);
    tick();
    ack_a = 1;
    tick();
    ack_a = 0;
    chk("r3_run", st_a, 0);
    en_a = 0;

    // five cores, two corrupted on different bits
    bus_b = {W, W ^ 97'h80, W, W ^ 97'h4, W};
    en_b = 1;
    #1;
    chk("n5_vote", voted_b, W);
    chk("n5_dis", dis_b, 5'b01010);
    tick();
    chk("n5_st_hold", st_b, 1);
    chk("n5_rbcnt", rbc_b, 1);
    bus_b = {W, W, W, W, W};
    tick();
    chk("n5_st_rb", st_b, 2);
    ack_b = 1;
    tick();
    ack_b = 0;
    chk("n5_run", st_b, 0);
    chk("n5_rbcnt_once", rbc_b, 1);
    chk("n5_fail", fail_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
